param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/param_updown_counter.sv | 104 ++++++++++
 tb/tb_param_updown_counter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with prescaler, load, hold and
// selectable wrap/saturate behaviour at the 0 and MAX_VAL bounds.
module param_updown_counter #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 255,
  parameter int DIV     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up,
  input  logic             down,
  input  logic             hold,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sat;
  logic             w_qualified;
  logic             w_tick;

  // A cycle only counts towards the prescaler when exactly one direction is
  // requested and neither load nor hold overrides it.
  assign w_qualified = !load && !hold && (up ^ down);

  generate
    if (DIV > 1) begin : g_prescale
      localparam int             PW       = $clog2(DIV);
      localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);

      logic [PW-1:0] r_prescale;

      assign w_tick = w_qualified && (r_prescale == PRE_LAST);

      // Prescaler counts qualified cycles; cleared by reset, load and on each tick.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_prescale <= '0;
        end else if (load || w_tick) begin
          r_prescale <= '0;
        end else if (w_qualified) begin
          r_prescale <= r_prescale + PW'(1);
        end
      end
    end else begin : g_no_prescale
      assign w_tick = w_qualified;
    end
  endgenerate

  // Count register plus one-cycle wrap/sat pulses; load is clamped to MAX_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
      if (load) begin
        r_count <= (load_val > MAX_CNT) ? MAX_CNT : load_val;
      end else if (w_tick) begin
        if (up) begin
          if (r_count == MAX_CNT) begin
            if (sat_mode) begin
              r_sat <= 1'b1;
            end else begin
              r_count <= '0;
              r_wrap  <= 1'b1;
            end
          end else begin
            r_count <= r_count + WIDTH'(1);
          end
        end else begin
          if (r_count == '0) begin
            if (sat_mode) begin
              r_sat <= 1'b1;
            end else begin
              r_count <= MAX_CNT;
              r_wrap  <= 1'b1;
            end
          end else begin
            r_count <= r_count - WIDTH'(1);
          end
        end
      end
    end
  end

  assign count  = r_count;
  assign wrap   = r_wrap;
  assign sat    = r_sat;
  assign at_max = (r_count == MAX_CNT);
  assign at_min = (r_count == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: two instances (DIV=1 and DIV=4, both
// MAX_VAL=9) share the same inputs and are checked against a counting model.
module tb_param_updown_counter;

  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       rst_n, up, down, hold, load, sat_mode;
  logic [7:0] load_val;

  logic [7:0] c1, c4;
  logic       am1, an1, w1, s1;
  logic       am4, an4, w4, s4;

  int checks = 0;
  int passes = 0;

  int mCnt[2];
  int mPre[2];
  bit mWrap[2];
  bit mSat[2];
  int mDiv[2] = '{1, 4};

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(8), .MAX_VAL(MAXV), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .up(up), .down(down), .hold(hold),
    .load(load), .load_val(load_val), .sat_mode(sat_mode),
    .count(c1), .at_max(am1), .at_min(an1), .wrap(w1), .sat(s1)
  );

  param_updown_counter #(.WIDTH(8), .MAX_VAL(MAXV), .DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .up(up), .down(down), .hold(hold),
    .load(load), .load_val(load_val), .sat_mode(sat_mode),
    .count(c4), .at_max(am4), .at_min(an4), .wrap(w4), .sat(s4)
  );

  // Reference: counts qualified cycles modulo DIV and moves the count
  // modulo MAX_VAL+1, or blocks and flags sat in saturating mode.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      mWrap[k] = 1'b0;
      mSat[k]  = 1'b0;
      if (!rst_n) begin
        mCnt[k] = 0;
        mPre[k] = 0;
      end else if (load) begin
        mCnt[k] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
        mPre[k] = 0;
      end else if (!hold && (up != down)) begin
        mPre[k] = (mPre[k] + 1) % mDiv[k];
        if (mPre[k] == 0) begin
          if (up) begin
            if (mCnt[k] == MAXV && sat_mode) mSat[k] = 1'b1;
            else begin
              mWrap[k] = (mCnt[k] == MAXV);
              mCnt[k]  = (mCnt[k] + 1) % (MAXV + 1);
            end
          end else begin
            if (mCnt[k] == 0 && sat_mode) mSat[k] = 1'b1;
            else begin
              mWrap[k] = (mCnt[k] == 0);
              mCnt[k]  = (mCnt[k] + MAXV) % (MAXV + 1);
            end
          end
        end
      end
    end
  endtask

  function automatic logic [11:0] expVec(input int k);
    return {8'(mCnt[k]), mWrap[k], mSat[k], mCnt[k] == MAXV, mCnt[k] == 0};
  endfunction

  function automatic logic [11:0] obsVec(input int k);
    if (k == 0) return {c1, w1, s1, am1, an1};
    return {c4, w4, s4, am4, an4};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_inputs(input bit u, input bit d, input bit h, input bit l,
                            input logic [7:0] lv, input bit sm);
    up = u; down = d; hold = h; load = l; load_val = lv; sat_mode = sm;
  endtask

  task automatic test_reset();
    set_inputs(0, 0, 0, 0, 8'd0, 0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) mCnt[k] = 0;
    for (int k = 0; k < 2; k++) mPre[k] = 0;
    checks++;
    if ({c1, w1, s1, am1, an1, c4, w4, s4, am4, an4} !== {8'd0, 4'b0001, 8'd0, 4'b0001})
      $display("[TB] FAIL reset_state got c1=%0d w1=%b s1=%b c4=%0d w4=%b s4=%b want zeros/at_min",
               c1, w1, s1, c4, w4, s4);
    else passes++;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obsVec(k) !== expVec(k))
        $display("[TB] FAIL reset_release[%0d] got %h want %h", k, obsVec(k), expVec(k));
      else passes++;
    end
  endtask

  task automatic test_wrap_up();
    set_inputs(1, 0, 0, 0, 8'd0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (c1 !== 8'((i + 1) % 10) || w1 !== (i == 9) || s1 !== 1'b0)
        $display("[TB] FAIL wrap_up step %0d got count=%0d wrap=%b sat=%b want count=%0d wrap=%b sat=0",
                 i, c1, w1, s1, (i + 1) % 10, (i == 9));
      else passes++;
      checks++;
      if (obsVec(1) !== expVec(1))
        $display("[TB] FAIL wrap_up_div4 step %0d got %h want %h", i, obsVec(1), expVec(1));
      else passes++;
    end
  endtask

  task automatic test_sat_down();
    set_inputs(0, 0, 0, 1, 8'd0, 1);
    tick();
    set_inputs(0, 1, 0, 0, 8'd0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (c1 !== 8'd0 || s1 !== 1'b1 || w1 !== 1'b0 || an1 !== 1'b1)
        $display("[TB] FAIL sat_down step %0d got count=%0d sat=%b wrap=%b at_min=%b want 0/1/0/1",
                 i, c1, s1, w1, an1);
      else passes++;
      checks++;
      if (obsVec(1) !== expVec(1))
        $display("[TB] FAIL sat_down_div4 step %0d got %h want %h", i, obsVec(1), expVec(1));
      else passes++;
    end
  endtask

  task automatic test_prescale();
    int q;
    set_inputs(0, 0, 0, 1, 8'd0, 0);
    tick();
    q = 0;
    for (int i = 0; i < 17; i++) begin
      if (i >= 6 && i < 11) set_inputs(1, 0, 1, 0, 8'd0, 0);
      else begin
        set_inputs(1, 0, 0, 0, 8'd0, 0);
        q++;
      end
      tick();
      checks++;
      if (c4 !== 8'(q / 4) || obsVec(1) !== expVec(1))
        $display("[TB] FAIL prescale cycle %0d got count=%0d want %0d (vec %h model %h)",
                 i, c4, q / 4, obsVec(1), expVec(1));
      else passes++;
    end
  endtask

  task automatic test_load_clamp();
    set_inputs(1, 0, 1, 1, 8'd200, 0);
    tick();
    checks++;
    if (c1 !== 8'd9 || c4 !== 8'd9 || am1 !== 1'b1 || am4 !== 1'b1)
      $display("[TB] FAIL load_clamp got c1=%0d c4=%0d am1=%b am4=%b want 9/9/1/1", c1, c4, am1, am4);
    else passes++;
    set_inputs(1, 0, 0, 0, 8'd0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (c4 !== ((i == 3) ? 8'd0 : 8'd9) || w4 !== (i == 3))
        $display("[TB] FAIL load_prescale_clear step %0d got count=%0d wrap=%b want %0d/%b",
                 i, c4, w4, (i == 3) ? 0 : 9, (i == 3));
      else passes++;
      checks++;
      if (obsVec(0) !== expVec(0))
        $display("[TB] FAIL load_div1 step %0d got %h want %h", i, obsVec(0), expVec(0));
      else passes++;
    end
  endtask

  task automatic test_both_dirs();
    logic [7:0] before4;
    set_inputs(1, 0, 0, 0, 8'd0, 0);
    tick();
    tick();
    before4 = c4;
    set_inputs(1, 1, 0, 0, 8'd0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsVec(k) !== expVec(k))
          $display("[TB] FAIL both_dirs[%0d] step %0d got %h want %h", k, i, obsVec(k), expVec(k));
        else passes++;
      end
    end
    set_inputs(1, 0, 0, 0, 8'd0, 0);
    tick();
    tick();
    checks++;
    if (c4 !== before4 + 8'd1 || obsVec(1) !== expVec(1))
      $display("[TB] FAIL both_dirs_prescale_kept got count=%0d want %0d", c4, before4 + 8'd1);
    else passes++;
  endtask

  task automatic test_async_reset();
    set_inputs(0, 0, 0, 1, 8'd7, 0);
    tick();
    set_inputs(1, 0, 0, 0, 8'd0, 0);
    tick();
    tick();
    checks++;
    if (c4 !== 8'd7)
      $display("[TB] FAIL async_pre_count got count=%0d want 7", c4);
    else passes++;
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      mCnt[k] = 0;
      mPre[k] = 0;
      mWrap[k] = 1'b0;
      mSat[k] = 1'b0;
    end
    checks++;
    if (c1 !== 8'd0 || c4 !== 8'd0 || an4 !== 1'b1 || am4 !== 1'b0)
      $display("[TB] FAIL async_reset got c1=%0d c4=%0d at_min=%b at_max=%b want 0/0/1/0",
               c1, c4, an4, am4);
    else passes++;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (c4 !== ((i == 3) ? 8'd1 : 8'd0) || obsVec(1) !== expVec(1))
        $display("[TB] FAIL async_release step %0d got count=%0d want %0d", i, c4, (i == 3) ? 1 : 0);
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_inputs($urandom % 2, $urandom % 2, ($urandom % 8) == 0, ($urandom % 16) == 0,
                 8'($urandom % 256), $urandom % 2);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsVec(k) !== expVec(k))
          $display("[TB] FAIL random[%0d] cycle %0d got %h want %h", k, i, obsVec(k), expVec(k));
        else passes++;
      end
    end
  endtask

  // Runs every scenario in sequence, then prints the summary.
  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_prescale();
    test_load_clamp();
    test_both_dirs();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
